streebog_seq: RTL

STREEBOG_SEQ -- requirements
Module: streebog_seq

---
 rtl/streebog_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/streebog_seq.sv
`default_nettype none
// ============================================================================
// streebog_seq -- Streebog block sequencer: message, padding, N and Sigma steps
// Optional macro STREEBOG_HASH256_EN: 256-bit IV and digest. Revision: 1.0
// ============================================================================
module streebog_seq #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] msg_data_i,
  input  logic [9:0]            msg_len_i,
  input  logic                  msg_last_i,
  input  logic                  msg_valid_i,
  output logic                  msg_ready_o,
  output logic [DATA_WIDTH-1:0] g_n_data_o,
  output logic [DATA_WIDTH-1:0] g_m_data_o,
  output logic [DATA_WIDTH-1:0] g_h_data_o,
  output logic                  g_valid_o,
  input  logic [DATA_WIDTH-1:0] g_hash_data_i,
  input  logic                  g_hash_valid_i,
  output logic [DATA_WIDTH-1:0] digest_o,
  output logic                  digest_valid_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    G_MSG   = 3'd1,
    G_PAD   = 3'd2,
    G_FIN_N = 3'd3,
    G_FIN_S = 3'd4
  } state_t;

`ifdef STREEBOG_HASH256_EN
  localparam logic [DATA_WIDTH-1:0] c_iv = {(DATA_WIDTH/8){8'h01}};
`else
  localparam logic [DATA_WIDTH-1:0] c_iv = '0;
`endif
  localparam logic [DATA_WIDTH-1:0] c_one      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [9:0]            c_full_len = 10'(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] n_q, n_d;
  logic [DATA_WIDTH-1:0] sigma_q, sigma_d;
  logic                  last_q, last_d;
  logic                  full_q, full_d;
  logic                  ready_q, ready_d;
  logic [DATA_WIDTH-1:0] g_n_q, g_n_d;
  logic [DATA_WIDTH-1:0] g_m_q, g_m_d;
  logic [DATA_WIDTH-1:0] g_h_q, g_h_d;
  logic                  g_valid_q, g_valid_d;
  logic [DATA_WIDTH-1:0] digest_q, digest_d;
  logic                  digest_valid_q, digest_valid_d;

  logic                  blk_full;
  logic [9:0]            blk_len;
  logic [DATA_WIDTH-1:0] blk_mask;
  logic [DATA_WIDTH-1:0] blk_pad_bit;
  logic [DATA_WIDTH-1:0] blk_m;
  logic [DATA_WIDTH-1:0] digest_shaped;

  // Non-last blocks always count as full regardless of msg_len_i.
  always_comb begin
    blk_full    = !msg_last_i || (msg_len_i >= c_full_len);
    blk_len     = blk_full ? c_full_len : msg_len_i;
    blk_mask    = ~({DATA_WIDTH{1'b1}} << blk_len);
    blk_pad_bit = c_one << blk_len;
    blk_m       = blk_full ? msg_data_i : ((msg_data_i & blk_mask) | blk_pad_bit);
  end

`ifdef STREEBOG_HASH256_EN
  assign digest_shaped = {{(DATA_WIDTH/2){1'b0}}, g_hash_data_i[DATA_WIDTH-1:DATA_WIDTH/2]};
`else
  assign digest_shaped = g_hash_data_i;
`endif

  always_comb begin
    state_d        = state_q;
    h_d            = h_q;
    n_d            = n_q;
    sigma_d        = sigma_q;
    last_d         = last_q;
    full_d         = full_q;
    g_n_d          = g_n_q;
    g_m_d          = g_m_q;
    g_h_d          = g_h_q;
    g_valid_d      = 1'b0;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (msg_valid_i && ready_q) begin
          g_n_d     = n_q;
          g_m_d     = blk_m;
          g_h_d     = h_q;
          g_valid_d = 1'b1;
          n_d       = n_q + {{(DATA_WIDTH-10){1'b0}}, blk_len};
          sigma_d   = sigma_q + blk_m;
          last_d    = msg_last_i;
          full_d    = blk_full;
          state_d   = G_MSG;
        end
      end
      G_MSG: begin
        if (g_hash_valid_i) begin
          h_d = g_hash_data_i;
          if (!last_q) begin
            state_d = IDLE;
          end else if (full_q) begin
            // A full final block still needs an all-padding block.
            state_d   = G_PAD;
            g_n_d     = n_q;
            g_m_d     = c_one;
            g_h_d     = g_hash_data_i;
            g_valid_d = 1'b1;
            sigma_d   = sigma_q + c_one;
          end else begin
            state_d   = G_FIN_N;
            g_n_d     = '0;
            g_m_d     = n_q;
            g_h_d     = g_hash_data_i;
            g_valid_d = 1'b1;
          end
        end
      end
      G_PAD: begin
        if (g_hash_valid_i) begin
          h_d       = g_hash_data_i;
          state_d   = G_FIN_N;
          g_n_d     = '0;
          g_m_d     = n_q;
          g_h_d     = g_hash_data_i;
          g_valid_d = 1'b1;
        end
      end
      G_FIN_N: begin
        if (g_hash_valid_i) begin
          h_d       = g_hash_data_i;
          state_d   = G_FIN_S;
          g_n_d     = '0;
          g_m_d     = sigma_q;
          g_h_d     = g_hash_data_i;
          g_valid_d = 1'b1;
        end
      end
      G_FIN_S: begin
        if (g_hash_valid_i) begin
          state_d        = IDLE;
          digest_d       = digest_shaped;
          digest_valid_d = 1'b1;
          h_d            = c_iv;
          n_d            = '0;
          sigma_d        = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      h_q            <= c_iv;
      n_q            <= '0;
      sigma_q        <= '0;
      last_q         <= 1'b0;
      full_q         <= 1'b0;
      ready_q        <= 1'b0;
      g_n_q          <= '0;
      g_m_q          <= '0;
      g_h_q          <= '0;
      g_valid_q      <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      h_q            <= h_d;
      n_q            <= n_d;
      sigma_q        <= sigma_d;
      last_q         <= last_d;
      full_q         <= full_d;
      ready_q        <= ready_d;
      g_n_q          <= g_n_d;
      g_m_q          <= g_m_d;
      g_h_q          <= g_h_d;
      g_valid_q      <= g_valid_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign msg_ready_o    = ready_q;
  assign g_n_data_o     = g_n_q;
  assign g_m_data_o     = g_m_q;
  assign g_h_data_o     = g_h_q;
  assign g_valid_o      = g_valid_q;
  assign digest_o       = digest_q;
  assign digest_valid_o = digest_valid_q;

endmodule
`default_nettype wire
